// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: instruction/data request ports and the shared SRAM port.
// slave is the arbiter's view; master drives requests and models the SRAM.
interface sram_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_addr_ok;
    logic          i_data_ok;
    logic [DW-1:0] i_rdata;
    logic            d_req;
    logic            d_wr;
    logic [DW/8-1:0] d_wstrb;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_addr_ok;
    logic            d_data_ok;
    logic [DW-1:0]   d_rdata;
    logic            ram_en;
    logic [DW/8-1:0] ram_wen;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, ram_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               ram_en, ram_wen, ram_addr, ram_wdata
    );
    modport master (
        output i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, ram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               ram_en, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1-cycle-latency SRAM between inst fetch and data access.
// ARB_RR_EN selects round-robin; otherwise data has priority with an inst starvation guard.
module sram_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst_n,
    sram_port_arbiter_if.slave bus
);
    logic i_req, d_req, grant_i, grant_d;
    logic resp_vld_q, resp_owner_q;
    // requests are masked in reset so nothing reaches the SRAM
    assign i_req = bus.i_req & rst_n;
    assign d_req = bus.d_req & rst_n;
`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
    always_comb begin
        grant_i  = i_req & (~d_req | last_d_q);
        grant_d  = d_req & ~grant_i;
        last_d_d = grant_i ? 1'b0 : (grant_d ? 1'b1 : last_d_q);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_d_q <= 1'b1;
        else        last_d_q <= last_d_d;
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    // an ungranted pending inst request means data just won a contention
    always_comb begin
        grant_i      = i_req & (~d_req | (starve_cnt_q == LIMIT));
        grant_d      = d_req & ~grant_i;
        starve_cnt_d = (grant_i | ~i_req) ? '0 :
                       ((starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) starve_cnt_q <= '0;
        else        starve_cnt_q <= starve_cnt_d;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            resp_vld_q   <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            resp_vld_q   <= grant_i | grant_d;
            resp_owner_q <= grant_d;
        end
    assign bus.i_addr_ok = grant_i;
    assign bus.d_addr_ok = grant_d;
    assign bus.ram_en    = grant_i | grant_d;
    assign bus.ram_wen   = (grant_d & bus.d_wr) ? bus.d_wstrb : '0;
    assign bus.ram_addr  = grant_d ? bus.d_addr : bus.i_addr;
    assign bus.ram_wdata = bus.d_wdata;
    assign bus.i_data_ok = resp_vld_q & ~resp_owner_q;
    assign bus.d_data_ok = resp_vld_q & resp_owner_q;
    assign bus.i_rdata   = bus.ram_rdata;
    assign bus.d_rdata   = bus.ram_rdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks of grants, responses and reset
// against a reference model of the arbitration rules.
module tb_sram_port_arbiter;
    localparam int STARVE = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int losses = 0;
    bit last_d = 1'b1;
    bit rv = 1'b0;
    bit ro = 1'b0;
    bit g_i = 1'b0;
    bit g_d = 1'b0;

    sram_port_arbiter_if #(.AW(32), .DW(32)) bus ();
    sram_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        losses = 0;
        last_d = 1'b1;
        rv = 1'b0;
        ro = 1'b0;
    endtask

    // one clock: check all outputs at the falling edge, then advance the model
    task automatic cyc();
        bit both;
        @(negedge clk);
        both = bus.i_req && bus.d_req;
        if (!rst_n) begin
            g_i = 1'b0;
            g_d = 1'b0;
        end else begin
`ifdef ARB_RR_EN
            g_i = bus.i_req && (!bus.d_req || last_d);
`else
            g_i = bus.i_req && (!bus.d_req || losses >= STARVE);
`endif
            g_d = bus.d_req && !g_i;
        end
        chk("i_addr_ok", bus.i_addr_ok, g_i);
        chk("d_addr_ok", bus.d_addr_ok, g_d);
        chk("ram_en", bus.ram_en, g_i || g_d);
        chk("ram_wen", bus.ram_wen, (g_d && bus.d_wr) ? bus.d_wstrb : 4'h0);
        if (g_i || g_d) chk("ram_addr", bus.ram_addr, g_d ? bus.d_addr : bus.i_addr);
        if (g_d && bus.d_wr) chk("ram_wdata", bus.ram_wdata, bus.d_wdata);
        chk("i_data_ok", bus.i_data_ok, rv && !ro);
        chk("d_data_ok", bus.d_data_ok, rv && ro);
        if (rv && !ro) chk("i_rdata", bus.i_rdata, bus.ram_rdata);
        if (rv && ro && !bus.d_wr) chk("d_rdata", bus.d_rdata, bus.ram_rdata);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            rv = g_i || g_d;
            ro = g_d;
            if (g_i || g_d) last_d = g_d;
            if (both && g_d) losses++;
            else if (!bus.i_req || g_i) losses = 0;
        end
        #1;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_wstrb = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ram_rdata = '0;
        model_reset();
        cyc();
        cyc();
        // continuous contention straight out of reset
        bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_addr = 32'h80;
        rst_n = 1;
        for (int k = 0; k < 10; k++) begin
            #2;
`ifdef ARB_RR_EN
            chk("pattern_i", bus.i_addr_ok, (k % 2) == 0);
`else
            chk("pattern_i", bus.i_addr_ok, (k % 5) == 4);
`endif
            cyc();
        end
        bus.i_req = 0; bus.d_req = 0;
        cyc();
        // single inst read
        bus.i_req = 1; bus.i_addr = 32'h100;
        #2;
        chk("t1_addr_ok", bus.i_addr_ok, 1);
        chk("t1_ram_en", bus.ram_en, 1);
        chk("t1_ram_wen", bus.ram_wen, 0);
        cyc();
        bus.i_req = 0; bus.ram_rdata = 32'hDEADBEEF;
        #2;
        chk("t1_i_data_ok", bus.i_data_ok, 1);
        chk("t1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk("t1_d_data_ok", bus.d_data_ok, 0);
        cyc();
        // single data write
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 32'h200; bus.d_wstrb = 4'b0011;
        bus.d_wdata = 32'h12345678;
        #2;
        chk("t2_ram_wen", bus.ram_wen, 4'b0011);
        chk("t2_ram_addr", bus.ram_addr, 32'h200);
        chk("t2_d_addr_ok", bus.d_addr_ok, 1);
        cyc();
        bus.d_req = 0; bus.d_wr = 0;
        #2;
        chk("t2_d_data_ok", bus.d_data_ok, 1);
        cyc();
        // alternating single requests I,D,I with no bubbles
        for (int k = 0; k < 3; k++) begin
            bus.i_req = (k % 2) == 0; bus.d_req = (k % 2) == 1;
            bus.i_addr = 32'h300 + k; bus.d_addr = 32'h400 + k;
            bus.ram_rdata = 32'hA000 + k;
            cyc();
        end
        bus.i_req = 0; bus.d_req = 0;
        #2;
        chk("alt_last_i_ok", bus.i_data_ok, 1);
        cyc();
        // reset in the cycle after a data grant drops the response
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h500;
        cyc();
        rst_n = 0; model_reset();
        bus.i_req = 1;
        #2;
        chk("rst_d_data_ok", bus.d_data_ok, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        cyc();
        cyc();
        bus.i_req = 0;
        rst_n = 1;
        #2;
        chk("rst_release_grant", bus.d_addr_ok, 1);
        cyc();
        // random traffic; losers hold their request until accepted
        for (int n = 0; n < 2000; n++) begin
            if (!(bus.i_req && !g_i)) begin
                bus.i_req = $urandom_range(0, 3) != 0;
                bus.i_addr = $urandom;
            end
            if (!(bus.d_req && !g_d)) begin
                bus.d_req = $urandom_range(0, 3) != 0;
                bus.d_wr = $urandom_range(0, 1) != 0;
                bus.d_wstrb = 4'($urandom);
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
            end
            bus.ram_rdata = $urandom;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the data-access requester of the pipelined core. Accepts at most one access per cycle, routes read data and write acknowledges back to the owner one cycle later, and prevents instruction-fetch starvation. Sits between the IF/MEM stages and the unified on-chip RAM.

## Interface
- AW, 32: address width.
- DW, 32: data width; byte strobes are DW/8 bits.
- STARVE_LIMIT, 4: consecutive lost contentions after which the instruction port wins (fixed-priority build only); must be ≥1.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request.
- i_addr  in  AW  instruction address.
- i_addr_ok  out  1  instruction request accepted this cycle.
- i_data_ok  out  1  i_rdata valid this cycle.
- i_rdata  out  DW  instruction read data.
- d_req  in  1  data request.
- d_wr  in  1  1 = write, 0 = read.
- d_wstrb  in  DW/8  write byte enables (ignored for reads).
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_addr_ok  out  1  data request accepted this cycle.
- d_data_ok  out  1  read data valid / write complete this cycle.
- d_rdata  out  DW  data read data.
- ram_en  out  1  SRAM access enable.
- ram_wen  out  DW/8  SRAM byte write enables.
- ram_addr  out  AW  SRAM address.
- ram_wdata  out  DW  SRAM write data.
- ram_rdata  in  DW  SRAM read data, valid the cycle after ram_en.

## Operation
- Grant is combinational per cycle: only one of i_req/d_req high → that port granted; both high → arbitration policy (Configuration); neither → no grant, ram_en=0.
- Granted port: its addr_ok=1; ram_en=1; ram_addr from that port; ram_wen = d_wstrb if data write, else 0; ram_wdata = d_wdata (don't-care for reads). Loser's addr_ok=0; it must hold its request stable until accepted.
- Response register: resp_vld, resp_owner (0=inst, 1=data), loaded every cycle with grant/owner of the current cycle.
- Cycle after grant: resp_vld=1 → owner's data_ok=1; i_rdata and d_rdata both driven by ram_rdata (pass-through, no storage); non-owner data_ok=0.
- Fully pipelined: new grant in cycle T+1 while response of T returns; back-to-back accesses from either port at one per cycle.
- Writes return d_data_ok like reads; d_rdata undefined for writes.
- Reset: while reset low, ram_en=0, all addr_ok=0, resp_vld=0, starve_cnt=0, rr pointer=data. All data_ok outputs 0. Reset asserted mid-access drops the in-flight response; requesters reissue after release.

## Timing
- Request to addr_ok: 0 cycles (same cycle, combinational).
- addr_ok to data_ok: exactly 1 cycle; no other latency exists.
- Throughput: 1 access/cycle aggregate.
- Combinational paths: i_req/d_req → addr_ok, ram_*; ram_rdata → i_rdata/d_rdata.
- Reset release: first grant possible in the first cycle reset is high.

## Configuration
- ARB_RR_EN defined: round-robin. On contention, grant the port not granted most recently; pointer updates on every grant to the granted port; reset value = data, so first contention goes to inst. No starvation counter.
- ARB_RR_EN undefined: data port has fixed priority. starve_cnt ($clog2(STARVE_LIMIT+1) bits) increments on each contention cycle data wins; when starve_cnt == STARVE_LIMIT, inst wins the contention. starve_cnt clears when inst is granted or i_req=0; saturates at STARVE_LIMIT.

## Test plan
- i_req only, i_addr=0x100, ram_rdata=0xDEADBEEF next cycle → i_addr_ok=1, ram_en=1, ram_wen=0 in T; i_data_ok=1, i_rdata=0xDEADBEEF in T+1, d_data_ok=0.
- d_req write, d_addr=0x200, d_wstrb=4'b0011, d_wdata=0x12345678 → ram_wen=0011, ram_addr=0x200, d_addr_ok=1 in T; d_data_ok=1 in T+1.
- Both requesting continuously, fixed priority, STARVE_LIMIT=4 → grants D,D,D,D,I repeating; i_addr_ok every 5th cycle.
- Both requesting continuously with ARB_RR_EN → grants I,D,I,D from reset; data_ok alternates owners one cycle behind.
- Alternating single requests I,D,I each cycle → each data_ok on the correct port exactly one cycle after its addr_ok, no bubbles.
- Assert reset low in cycle after a d_req grant → d_data_ok stays 0, ram_en=0 during reset; first request after release granted immediately.
